// File: rtl/fpga_slave_pkg.sv
// Shared types and default thresholds for the discharge pulse classifier and
// the discharge_control block that consumes its short flag.
package fpga_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OBSERVE  = 2'd1,
        ST_CLASSIFY = 2'd2
    } sort_state_t;

    typedef enum logic [1:0] {
        CLS_NULL   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_SHORT  = 2'd2
    } pulse_class_t;

    localparam logic [15:0] V_OPEN_TH_DEF     = 16'd2800;
    localparam logic [15:0] V_SHORT_TH_DEF    = 16'd300;
    localparam logic [7:0]  BLANK_CYC_DEF     = 8'd20;
    localparam logic [7:0]  SHORT_MIN_DEF     = 8'd10;
    localparam logic [15:0] WINDOW_PULSES_DEF = 16'd100;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_sort_stat.sv
// Window accumulator: counts classified pulses per class and publishes the
// three totals with a one-cycle strobe once the window is full.
module pulse_sort_stat
    import fpga_slave_pkg::*;
#(
    parameter logic [15:0] WINDOW_PULSES = WINDOW_PULSES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] pulse_class,
    input  logic       class_valid,
    output logic [7:0] null_pulse_num,
    output logic [7:0] normal_pulse_num,
    output logic [7:0] short_pulse_num,
    output logic       stat_valid
);

    logic [7:0]  acc_null, acc_normal, acc_short;
    logic [7:0]  nxt_null, nxt_normal, nxt_short;
    logic [15:0] pulse_cnt;
    logic        window_done;

    always_comb begin
        nxt_null   = acc_null;
        nxt_normal = acc_normal;
        nxt_short  = acc_short;
        if (class_valid) begin
            case (pulse_class)
                CLS_NULL:   nxt_null   = sat_inc8(acc_null);
                CLS_NORMAL: nxt_normal = sat_inc8(acc_normal);
                CLS_SHORT:  nxt_short  = sat_inc8(acc_short);
                default:    ;
            endcase
        end
        window_done = class_valid && ((pulse_cnt + 16'd1) == WINDOW_PULSES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_null         <= '0;
            acc_normal       <= '0;
            acc_short        <= '0;
            pulse_cnt        <= '0;
            null_pulse_num   <= '0;
            normal_pulse_num <= '0;
            short_pulse_num  <= '0;
            stat_valid       <= 1'b0;
        end else if (clear) begin
            // published counts deliberately hold across a clear
            acc_null   <= '0;
            acc_normal <= '0;
            acc_short  <= '0;
            pulse_cnt  <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= window_done;
            if (window_done) begin
                null_pulse_num   <= nxt_null;
                normal_pulse_num <= nxt_normal;
                short_pulse_num  <= nxt_short;
                acc_null         <= '0;
                acc_normal       <= '0;
                acc_short        <= '0;
                pulse_cnt        <= '0;
            end else if (class_valid) begin
                acc_null   <= nxt_null;
                acc_normal <= nxt_normal;
                acc_short  <= nxt_short;
                pulse_cnt  <= pulse_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pulse_sort.sv
// Discharge pulse classifier: watches gap voltage during Ton and sorts each
// pulse into null / normal / short, raising an early short flag mid-pulse.
//
// state       | meaning
// ST_IDLE     | waiting for a pulse_on rising edge
// ST_OBSERVE  | inside Ton, tracking samples after the blanking interval
// ST_CLASSIFY | one cycle after Ton falls, hands the class to the window stats
module pulse_sort
    import fpga_slave_pkg::*;
#(
    parameter logic [15:0] V_OPEN_TH     = V_OPEN_TH_DEF,
    parameter logic [15:0] V_SHORT_TH    = V_SHORT_TH_DEF,
    parameter logic [7:0]  BLANK_CYC     = BLANK_CYC_DEF,
    parameter logic [7:0]  SHORT_MIN     = SHORT_MIN_DEF,
    parameter logic [15:0] WINDOW_PULSES = WINDOW_PULSES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_voltage,
    input  logic        sample_valid,
    input  logic        pulse_on,
    input  logic        clear,
    output logic [7:0]  null_pulse_num,
    output logic [7:0]  normal_pulse_num,
    output logic [7:0]  short_pulse_num,
    output logic        stat_valid,
    output logic        pro1_short_flag
);

    sort_state_t  state, state_next;
    pulse_class_t pulse_class;
    logic         pulse_on_d, rise, start_pulse, qualify, class_valid;
    logic         brk_seen, short_seen;
    logic [7:0]   cyc_cnt, short_run, short_run_inc;

    // Edge register resets high so a pulse already running at reset release is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse_on_d <= 1'b1;
        else        pulse_on_d <= pulse_on;
    end

    assign rise = pulse_on & ~pulse_on_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (rise) state_next = ST_OBSERVE;
            ST_OBSERVE:  if (!pulse_on) state_next = ST_CLASSIFY;
            ST_CLASSIFY: state_next = rise ? ST_OBSERVE : ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
        if (clear) state_next = ST_IDLE;
    end

    assign start_pulse   = rise && !clear && (state == ST_IDLE || state == ST_CLASSIFY);
    assign qualify       = (state == ST_OBSERVE) && pulse_on && sample_valid && (cyc_cnt >= BLANK_CYC);
    assign short_run_inc = sat_inc8(short_run);
    assign class_valid   = (state == ST_CLASSIFY) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt         <= '0;
            short_run       <= '0;
            brk_seen        <= 1'b0;
            short_seen      <= 1'b0;
            pro1_short_flag <= 1'b0;
        end else if (clear || start_pulse) begin
            cyc_cnt         <= '0;
            short_run       <= '0;
            brk_seen        <= 1'b0;
            short_seen      <= 1'b0;
            pro1_short_flag <= 1'b0;
        end else if (state == ST_OBSERVE) begin
            cyc_cnt <= sat_inc8(cyc_cnt);
            if (qualify) begin
                if (sample_voltage <= V_SHORT_TH) begin
                    short_run <= short_run_inc;
                    if (short_run_inc >= SHORT_MIN) begin
                        short_seen      <= 1'b1;
                        pro1_short_flag <= 1'b1;
                    end
                end else if (sample_voltage < V_OPEN_TH) begin
                    brk_seen  <= 1'b1;
                    short_run <= '0;
                end else begin
                    short_run <= '0;
                end
            end
        end
    end

    always_comb begin
        pulse_class = CLS_NULL;
        if (short_seen)    pulse_class = CLS_SHORT;
        else if (brk_seen) pulse_class = CLS_NORMAL;
    end

    pulse_sort_stat #(
        .WINDOW_PULSES(WINDOW_PULSES)
    ) u_stat (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear),
        .pulse_class      (pulse_class),
        .class_valid      (class_valid),
        .null_pulse_num   (null_pulse_num),
        .normal_pulse_num (normal_pulse_num),
        .short_pulse_num  (short_pulse_num),
        .stat_valid       (stat_valid)
    );

endmodule

// File: tb/tb_pulse_sort.sv
// Bench for pulse_sort: directed and random pulses checked every cycle
// against a per-pulse behavioural classifier and window tally.
module tb_pulse_sort;

    localparam int WIN   = 6;
    localparam int BLANK = 20;
    localparam int SMIN  = 10;
    localparam int VSH   = 300;
    localparam int VOP   = 2800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_voltage = '0;
    logic        sample_valid = 1'b0;
    logic        pulse_on = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  null_pulse_num, normal_pulse_num, short_pulse_num;
    logic        stat_valid, pro1_short_flag;

    pulse_sort #(.WINDOW_PULSES(16'(WIN))) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_voltage   (sample_voltage),
        .sample_valid     (sample_valid),
        .pulse_on         (pulse_on),
        .clear            (clear),
        .null_pulse_num   (null_pulse_num),
        .normal_pulse_num (normal_pulse_num),
        .short_pulse_num  (short_pulse_num),
        .stat_valid       (stat_valid),
        .pro1_short_flag  (pro1_short_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // behavioural model state
    typedef struct {int at; int n; int m; int s;} stat_ev_t;
    stat_ev_t pq[$];
    int  pub_n = 0, pub_m = 0, pub_s = 0;
    int  mc_n = 0, mc_m = 0, mc_s = 0, mc_tot = 0;
    bit  exp_flag = 1'b0;
    bit  checking = 1'b0;

    logic [15:0] volt [256];
    bit          vld  [256];

    always @(negedge clk) begin
        if (checking) begin
            bit sv_exp;
            sv_exp = 1'b0;
            if (pq.size() > 0 && pq[0].at == cyc) begin
                sv_exp = 1'b1;
                pub_n = pq[0].n;
                pub_m = pq[0].m;
                pub_s = pq[0].s;
                void'(pq.pop_front());
            end
            chk("stat_valid", int'(stat_valid), int'(sv_exp));
            chk("null_cnt", int'(null_pulse_num), pub_n);
            chk("normal_cnt", int'(normal_pulse_num), pub_m);
            chk("short_cnt", int'(short_pulse_num), pub_s);
            chk("short_flag", int'(pro1_short_flag), int'(exp_flag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        pq.delete();
        pub_n = 0; pub_m = 0; pub_s = 0;
        mc_n = 0; mc_m = 0; mc_s = 0; mc_tot = 0;
        exp_flag = 1'b0;
    endtask

    task automatic fill(input int a_len, input int va, input int vb);
        for (int t = 0; t < 256; t++) begin
            volt[t] = (t < a_len) ? 16'(va) : 16'(vb);
            vld[t]  = 1'b1;
        end
    endtask

    task automatic fill_random();
        int t, len, k;
        logic [15:0] v;
        t = 0;
        while (t < 256) begin
            len = $urandom_range(1, 15);
            k   = $urandom_range(0, 7);
            case (k)
                0, 1, 2: v = 16'($urandom_range(0, VSH));
                3:       v = 16'($urandom_range(VSH + 1, VOP - 1));
                4:       v = 16'($urandom_range(VOP, 4095));
                5:       v = 16'(VSH);
                6:       v = ($urandom_range(0, 1) != 0) ? 16'(VSH + 1) : 16'(VOP - 1);
                default: v = 16'(VOP);
            endcase
            for (int j = 0; j < len && t < 256; j++) begin
                volt[t] = v;
                vld[t]  = ($urandom_range(0, 9) != 0);
                t++;
            end
        end
    endtask

    // t = 0 is the rise cycle; the first observed cycle is t = 1 with
    // BLANK cycles of blanking counted from there.
    task automatic run_pulse(input int ton, input int gap, input int abort_at);
        int  run, t_s, cls;
        bit  brk;
        run = 0; t_s = -1; brk = 1'b0;
        for (int t = 1; t < ton; t++) begin
            if (vld[t] && (t - 1) >= BLANK) begin
                if (volt[t] <= VSH) begin
                    run++;
                    if (run == SMIN && t_s < 0) t_s = t;
                end else if (volt[t] < VOP) begin
                    brk = 1'b1;
                    run = 0;
                end else begin
                    run = 0;
                end
            end
        end
        cls = (t_s >= 0) ? 2 : (brk ? 1 : 0);
        for (int t = 0; t < ton + gap; t++) begin
            pulse_on       = (t < ton);
            sample_voltage = (t < ton) ? volt[t] : 16'($urandom_range(0, 4095));
            sample_valid   = (t < ton) ? vld[t] : ($urandom_range(0, 1) != 0);
            clear          = (t == abort_at);
            if (abort_at >= 0 && t > abort_at) begin
                exp_flag = 1'b0;
            end else if (t >= 1) begin
                exp_flag = (t_s >= 0 && t > t_s);
            end
            if (t == abort_at) begin
                mc_n = 0; mc_m = 0; mc_s = 0; mc_tot = 0;
            end
            if (t == ton && abort_at < 0) begin
                if (cls == 0) mc_n = (mc_n < 255) ? mc_n + 1 : 255;
                if (cls == 1) mc_m = (mc_m < 255) ? mc_m + 1 : 255;
                if (cls == 2) mc_s = (mc_s < 255) ? mc_s + 1 : 255;
                mc_tot++;
                if (mc_tot == WIN) begin
                    pq.push_back('{at: cyc + 2, n: mc_n, m: mc_m, s: mc_s});
                    mc_n = 0; mc_m = 0; mc_s = 0; mc_tot = 0;
                end
            end
            step();
        end
        clear = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        pulse_on = 1'b0;
        mc_n = 0; mc_m = 0; mc_s = 0; mc_tot = 0;
        step();
        clear = 1'b0;
        exp_flag = 1'b0;
        step();
    endtask

    task automatic chk_counts(input string name, input int n, input int m, input int s);
        chk({name, "_null"}, int'(null_pulse_num), n);
        chk({name, "_normal"}, int'(normal_pulse_num), m);
        chk({name, "_short"}, int'(short_pulse_num), s);
    endtask

    initial begin
        int ton, gap, ab;

        // reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk_counts("reset", 0, 0, 0);
        chk("reset_stat_valid", int'(stat_valid), 0);
        chk("reset_flag", int'(pro1_short_flag), 0);
        checking = 1'b1;

        // window 1: null, null (back-to-back), 3 normal, short
        fill(256, 3500, 3500);  run_pulse(60, 1, -1);
        fill(256, 3500, 3500);  run_pulse(60, 1, -1);
        fill(30, 3500, 1500);   run_pulse(60, 1, -1);
        fill(30, 3500, 1500);   run_pulse(60, 1, -1);
        fill(30, 3500, 1500);   run_pulse(60, 3, -1);
        fill(256, 100, 100);    run_pulse(60, 3, -1);
        chk("short_flag_held", int'(pro1_short_flag), 1);
        chk_counts("win1", 2, 3, 1);

        // window 2: 9 shorts then breakdown, blanked shorts, tiny Ton, short, 2 open
        fill(30, 100, 1500);    run_pulse(60, 2, -1);
        chk("nine_short_flag", int'(pro1_short_flag), 0);
        fill(21, 100, 3500);    run_pulse(60, 1, -1);
        fill(256, 100, 100);    run_pulse(10, 1, -1);
        fill(256, 100, 100);    run_pulse(60, 2, -1);
        fill(256, 3500, 3500);  run_pulse(60, 2, -1);
        fill(256, 3500, 3500);  run_pulse(60, 3, -1);
        chk_counts("win2", 4, 1, 1);

        // clear mid-window, then an aborted pulse, then a fresh window
        fill(30, 3500, 1500);   run_pulse(60, 2, -1);
        fill(30, 3500, 1500);   run_pulse(60, 2, -1);
        do_clear();
        chk_counts("after_clear", 4, 1, 1);
        fill(256, 100, 100);    run_pulse(60, 3, 40);
        chk("abort_flag", int'(pro1_short_flag), 0);
        for (int i = 0; i < WIN; i++) begin
            fill(256, 3500, 3500);
            run_pulse(60, 2, -1);
        end
        chk_counts("post_clear_win", WIN, 0, 0);

        // reset with pulse_on high: that pulse is ignored
        checking = 1'b0;
        pulse_on = 1'b1;
        sample_voltage = 16'd100;
        sample_valid = 1'b1;
        repeat (5) step();
        rst_n = 1'b0;
        repeat (3) step();
        model_reset();
        rst_n = 1'b1;
        checking = 1'b1;
        chk_counts("midpulse_reset", 0, 0, 0);
        repeat (40) step();
        pulse_on = 1'b0;
        repeat (3) step();

        // randomized pulses
        for (int i = 0; i < 90; i++) begin
            fill_random();
            ton = $urandom_range(1, 100);
            gap = $urandom_range(1, 4);
            ab  = (ton >= 3 && $urandom_range(0, 14) == 0) ? $urandom_range(1, ton - 1) : -1;
            run_pulse(ton, gap, ab);
        end
        repeat (4) step();
        checking = 1'b0;
        chk("pending_drained", pq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
